// File: rtl/cfo_calc_scheduler.sv
`default_nettype none
//==== cfo_calc_scheduler: round-robin sharing of one CFO_calc datapath, timeout watchdog, tagged result.
//==== Optional macro CFO_AVG_EN: exponential angle average drives the DDS increment.  Rev 1.0
module cfo_calc_scheduler #(
  parameter int N_REQ          = 3,
  parameter int C_DW           = 32,
  parameter int CFO_DW         = 20,
  parameter int DDS_DW         = 20,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int AVG_SHIFT      = 3
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic [N_REQ*C_DW-1:0]      req_C0_i,
  input  logic [N_REQ*C_DW-1:0]      req_C1_i,
  output logic [C_DW-1:0]            calc_C0_o,
  output logic [C_DW-1:0]            calc_C1_o,
  output logic                       calc_valid_o,
  input  logic [CFO_DW-1:0]          calc_angle_i,
  input  logic                       calc_valid_i,
  output logic [CFO_DW-1:0]          CFO_angle_o,
  output logic [$clog2(N_REQ)-1:0]   CFO_id_o,
  output logic                       valid_o,
  output logic                       timeout_o,
  output logic [DDS_DW-1:0]          CFO_DDS_inc_o,
  output logic                       DDS_valid_o
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ID_W:0]   N_REQ_L    = (ID_W + 1)'(N_REQ);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  if (N_REQ < 2 || N_REQ > 8 || AVG_SHIFT < 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("cfo_calc_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [C_DW-1:0]   c0_q, c0_d, c1_q, c1_d;
  logic [CFO_DW-1:0] angle_q, angle_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DDS_DW-1:0] dds_q, dds_d;
  logic              calc_valid_q, calc_valid_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;
  logic              dds_valid_q, dds_valid_d;

  logic [C_DW-1:0]   c0_arr [N_REQ];
  logic [C_DW-1:0]   c1_arr [N_REQ];
  logic              any_w;
  logic [ID_W-1:0]   grant_w;
  logic [ID_W:0]     cand_w;
  logic [ID_W:0]     grant_inc_w;
  logic [ID_W-1:0]   rr_next_w;
  logic [CFO_DW-1:0] dds_src_w;
  logic [DDS_DW-1:0] dds_map_w;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign c0_arr[k] = req_C0_i[k*C_DW +: C_DW];
    assign c1_arr[k] = req_C1_i[k*C_DW +: C_DW];
  end

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    any_w   = 1'b0;
    grant_w = '0;
    cand_w  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_w = {1'b0, rr_ptr_q} + (ID_W + 1)'(i);
      if (cand_w >= N_REQ_L) cand_w = cand_w - N_REQ_L;
      if (!any_w && req_valid_i[cand_w[ID_W-1:0]]) begin
        any_w   = 1'b1;
        grant_w = cand_w[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == S_IDLE && any_w) req_ready_o[grant_w] = 1'b1;
  end

  assign grant_inc_w = {1'b0, grant_q} + (ID_W + 1)'(1);
  assign rr_next_w   = (grant_inc_w >= N_REQ_L) ? '0 : grant_inc_w[ID_W-1:0];

`ifdef CFO_AVG_EN
  logic [CFO_DW-1:0]      avg_q, avg_d;
  logic                   avg_init_q, avg_init_d;
  logic signed [CFO_DW:0] avg_diff_w;
  logic [CFO_DW-1:0]      avg_sum_w;
  logic [CFO_DW-1:0]      avg_new_w;

  // One guard bit keeps the difference exact before the arithmetic shift.
  assign avg_diff_w = $signed({calc_angle_i[CFO_DW-1], calc_angle_i}) - $signed({avg_q[CFO_DW-1], avg_q});
  assign avg_sum_w  = CFO_DW'($signed({avg_q[CFO_DW-1], avg_q}) + (avg_diff_w >>> AVG_SHIFT));
  assign avg_new_w  = avg_init_q ? avg_sum_w : calc_angle_i;
  assign dds_src_w  = avg_new_w;
`else
  assign dds_src_w  = calc_angle_i;
`endif

  if (CFO_DW >= DDS_DW) begin : g_dds_trunc
    assign dds_map_w = dds_src_w[CFO_DW-1 -: DDS_DW];
  end else begin : g_dds_sext
    assign dds_map_w = {{(DDS_DW - CFO_DW){dds_src_w[CFO_DW-1]}}, dds_src_w};
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    timer_d      = timer_q;
    c0_d         = c0_q;
    c1_d         = c1_q;
    angle_d      = angle_q;
    id_d         = id_q;
    dds_d        = dds_q;
    calc_valid_d = 1'b0;
    valid_d      = 1'b0;
    timeout_d    = 1'b0;
    dds_valid_d  = 1'b0;
`ifdef CFO_AVG_EN
    avg_d        = avg_q;
    avg_init_d   = avg_init_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_w) begin
          grant_d      = grant_w;
          c0_d         = c0_arr[grant_w];
          c1_d         = c1_arr[grant_w];
          calc_valid_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        // A result arriving on the last watchdog cycle still counts.
        if (calc_valid_i) begin
          angle_d     = calc_angle_i;
          id_d        = grant_q;
          valid_d     = 1'b1;
          dds_d       = dds_map_w;
          dds_valid_d = 1'b1;
          rr_ptr_d    = rr_next_w;
          state_d     = S_OUTPUT;
`ifdef CFO_AVG_EN
          avg_d       = avg_new_w;
          avg_init_d  = 1'b1;
`endif
        end else if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          rr_ptr_d  = rr_next_w;
          state_d   = S_IDLE;
        end
      end
      S_OUTPUT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      timer_q      <= '0;
      c0_q         <= '0;
      c1_q         <= '0;
      angle_q      <= '0;
      id_q         <= '0;
      dds_q        <= '0;
      calc_valid_q <= 1'b0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      dds_valid_q  <= 1'b0;
`ifdef CFO_AVG_EN
      avg_q        <= '0;
      avg_init_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      timer_q      <= timer_d;
      c0_q         <= c0_d;
      c1_q         <= c1_d;
      angle_q      <= angle_d;
      id_q         <= id_d;
      dds_q        <= dds_d;
      calc_valid_q <= calc_valid_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
      dds_valid_q  <= dds_valid_d;
`ifdef CFO_AVG_EN
      avg_q        <= avg_d;
      avg_init_q   <= avg_init_d;
`endif
    end
  end

  assign calc_C0_o     = c0_q;
  assign calc_C1_o     = c1_q;
  assign calc_valid_o  = calc_valid_q;
  assign CFO_angle_o   = angle_q;
  assign CFO_id_o      = id_q;
  assign valid_o       = valid_q;
  assign timeout_o     = timeout_q;
  assign CFO_DDS_inc_o = dds_q;
  assign DDS_valid_o   = dds_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cfo_calc_scheduler.sv
`default_nettype none
//==== tb_cfo_calc_scheduler: scoreboard bench for cfo_calc_scheduler at default parameters.
//==== Expected results are queued when the calc answer is driven and popped on valid_o.  Rev 1.0
module tb_cfo_calc_scheduler;
  localparam int N_REQ  = 3;
  localparam int C_DW   = 32;
  localparam int CFO_DW = 20;
  localparam int DDS_DW = 20;
  localparam int ID_W   = 2;

  logic                  clk_i = 1'b0;
  logic                  reset_ni = 1'b0;
  logic [N_REQ-1:0]      req_valid_i = '0;
  logic [N_REQ-1:0]      req_ready_o;
  logic [N_REQ*C_DW-1:0] req_C0_i = '0;
  logic [N_REQ*C_DW-1:0] req_C1_i = '0;
  logic [C_DW-1:0]       calc_C0_o, calc_C1_o;
  logic                  calc_valid_o;
  logic [CFO_DW-1:0]     calc_angle_i = '0;
  logic                  calc_valid_i = 1'b0;
  logic [CFO_DW-1:0]     CFO_angle_o;
  logic [ID_W-1:0]       CFO_id_o;
  logic                  valid_o, timeout_o;
  logic [DDS_DW-1:0]     CFO_DDS_inc_o;
  logic                  DDS_valid_o;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [CFO_DW-1:0] angle;
    logic [DDS_DW-1:0] dds;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
`ifdef CFO_AVG_EN
  int   model_avg = 0;
  bit   model_init = 1'b0;
`endif

  cfo_calc_scheduler dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_C0_i(req_C0_i), .req_C1_i(req_C1_i),
    .calc_C0_o(calc_C0_o), .calc_C1_o(calc_C1_o), .calc_valid_o(calc_valid_o),
    .calc_angle_i(calc_angle_i), .calc_valid_i(calc_valid_i),
    .CFO_angle_o(CFO_angle_o), .CFO_id_o(CFO_id_o), .valid_o(valid_o), .timeout_o(timeout_o),
    .CFO_DDS_inc_o(CFO_DDS_inc_o), .DDS_valid_o(DDS_valid_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // Reference DDS increment; with averaging, a signed-integer exponential average with weight 1/8.
  function automatic logic [DDS_DW-1:0] model_dds(input logic [CFO_DW-1:0] a);
`ifdef CFO_AVG_EN
    int sa;
    sa = int'(a);
    if (a[CFO_DW-1]) sa = sa - (1 << CFO_DW);
    if (!model_init) model_avg = sa;
    else model_avg = model_avg + ((sa - model_avg) >>> 3);
    model_init = 1'b1;
    model_avg = model_avg & ((1 << CFO_DW) - 1);
    if (model_avg >= (1 << (CFO_DW - 1))) model_avg = model_avg - (1 << CFO_DW);
    return model_avg[CFO_DW-1:0];
`else
    return a;
`endif
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    reset_ni = 1'b0;
    req_valid_i = '0;
    calc_valid_i = 1'b0;
    calc_angle_i = '0;
    sb_q.delete();
    repeat (3) @(posedge clk_i);
    #1 reset_ni = 1'b1;
    step();
`ifdef CFO_AVG_EN
    model_init = 1'b0;
    model_avg = 0;
`endif
  endtask

  task automatic load_data();
    for (int k = 0; k < N_REQ; k++) begin
      req_C0_i[k*C_DW +: C_DW] = $urandom;
      req_C1_i[k*C_DW +: C_DW] = $urandom;
    end
  endtask

  // Raises the mask and returns once the grant edge has passed (DUT then in ISSUE).
  task automatic accept(input logic [N_REQ-1:0] mask, output logic [N_REQ-1:0] rdy, output bit ok);
    req_valid_i = mask;
    ok = 1'b0;
    rdy = '0;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if (req_ready_o != '0) begin
        rdy = req_ready_o;
        ok = 1'b1;
      end else begin
        step();
      end
    end
    if (ok) step();
  endtask

  task automatic respond(input int lat, input logic [CFO_DW-1:0] ang);
    repeat (lat) step();
    calc_valid_i = 1'b1;
    calc_angle_i = ang;
    step();
    calc_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if ({req_ready_o, calc_C0_o, calc_C1_o, calc_valid_o, CFO_angle_o, CFO_id_o, valid_o, timeout_o, CFO_DDS_inc_o, DDS_valid_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ready=%b angle=%h id=%0d valid=%b timeout=%b dds=%h calc_valid=%b, all required 0",
               req_ready_o, CFO_angle_o, CFO_id_o, valid_o, timeout_o, CFO_DDS_inc_o, calc_valid_o);
    end
  endtask

  task automatic test_single();
    logic [N_REQ-1:0] rdy;
    bit ok, got;
    int pulses;
    exp_t e;
    apply_reset();
    load_data();
    accept(3'b010, rdy, ok);
    req_valid_i = '0;
    tests_run++;
    if (!ok || rdy !== 3'b010) begin tests_failed++; $display("FAIL single_grant: ready=%b ok=%0d, required 010", rdy, ok); end
    tests_run++;
    if ({calc_valid_o, calc_C0_o, calc_C1_o} !== {1'b1, req_C0_i[C_DW +: C_DW], req_C1_i[C_DW +: C_DW]}) begin
      tests_failed++;
      $display("FAIL single_issue: calc_valid=%b C0=%h C1=%h, required 1 %h %h", calc_valid_o, calc_C0_o, calc_C1_o,
               req_C0_i[C_DW +: C_DW], req_C1_i[C_DW +: C_DW]);
    end
    pulses = 1;
    repeat (30) begin step(); if (calc_valid_o) pulses++; end
    e = '{id: 2'd1, angle: 20'h04000, dds: 20'h04000};
    void'(model_dds(20'h04000));
    sb_q.push_back(e);
    respond(0, 20'h04000);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin if (valid_o) got = 1'b1; else step(); end
    tests_run++;
    if (!got || sb_q.size() == 0) begin tests_failed++; $display("FAIL single_valid: valid_o not seen, queue=%0d", sb_q.size()); end
    else begin
      e = sb_q.pop_front();
      tests_run++;
      if ({CFO_id_o, CFO_angle_o, CFO_DDS_inc_o, DDS_valid_o} !== {e.id, e.angle, e.dds, 1'b1}) begin
        tests_failed++;
        $display("FAIL single_result: id=%0d angle=%h dds=%h dds_valid=%b, required %0d %h %h 1",
                 CFO_id_o, CFO_angle_o, CFO_DDS_inc_o, DDS_valid_o, e.id, e.angle, e.dds);
      end
      step();
      tests_run++;
      if ({valid_o, DDS_valid_o} !== 2'b00) begin tests_failed++; $display("FAIL single_pulse: valid/dds_valid=%b%b one cycle later, required 00", valid_o, DDS_valid_o); end
    end
    tests_run++;
    if (pulses != 1) begin tests_failed++; $display("FAIL single_calc_pulses: %0d calc_valid_o cycles, required 1", pulses); end
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] rdy, exp_rdy;
    logic [ID_W-1:0] exp_id;
    logic [CFO_DW-1:0] ang;
    bit ok, got;
    exp_t e;
    apply_reset();
    load_data();
    for (int n = 0; n < 6; n++) begin
      exp_id = ID_W'(n % N_REQ);
      exp_rdy = N_REQ'(1 << (n % N_REQ));
      accept(3'b111, rdy, ok);
      tests_run++;
      if (!ok || rdy !== exp_rdy) begin tests_failed++; $display("FAIL rr_grant_%0d: ready=%b, required %b", n, rdy, exp_rdy); end
      tests_run++;
      if (calc_C0_o !== req_C0_i[exp_id*C_DW +: C_DW]) begin tests_failed++; $display("FAIL rr_data_%0d: C0=%h, required %h", n, calc_C0_o, req_C0_i[exp_id*C_DW +: C_DW]); end
      ang = CFO_DW'($urandom);
      e = '{id: exp_id, angle: ang, dds: model_dds(ang)};
      sb_q.push_back(e);
      respond(2 + n, ang);
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin if (valid_o) got = 1'b1; else step(); end
      tests_run++;
      if (!got || sb_q.size() == 0) begin tests_failed++; $display("FAIL rr_valid_%0d: valid_o not seen", n); end
      else begin
        e = sb_q.pop_front();
        if ({CFO_id_o, CFO_angle_o, CFO_DDS_inc_o} !== {e.id, e.angle, e.dds}) begin
          tests_failed++;
          $display("FAIL rr_result_%0d: id=%0d angle=%h dds=%h, required %0d %h %h", n, CFO_id_o, CFO_angle_o, CFO_DDS_inc_o, e.id, e.angle, e.dds);
        end
      end
    end
    req_valid_i = '0;
  endtask

  task automatic test_timeout();
    logic [N_REQ-1:0] rdy;
    bit ok, got, saw_valid;
    int n;
    exp_t e;
    apply_reset();
    load_data();
    accept(3'b001, rdy, ok);
    req_valid_i = '0;
    tests_run++;
    if (!ok || rdy !== 3'b001) begin tests_failed++; $display("FAIL to_grant: ready=%b, required 001", rdy); end
    n = 0;
    saw_valid = 1'b0;
    got = 1'b0;
    while (n < 100 && !got) begin
      step();
      n++;
      if (valid_o) saw_valid = 1'b1;
      if (timeout_o) got = 1'b1;
    end
    // CFO_calc captures the issue pulse one edge after grant; the watchdog fires 64 cycles later.
    tests_run++;
    if (!got || n != 65) begin tests_failed++; $display("FAIL to_latency: timeout_o seen=%0d after %0d cycles, required 65", got, n); end
    tests_run++;
    if (saw_valid) begin tests_failed++; $display("FAIL to_no_valid: valid_o=1 during timeout, required 0"); end
    step();
    tests_run++;
    if (timeout_o !== 1'b0) begin tests_failed++; $display("FAIL to_pulse: timeout_o=%b one cycle later, required 0", timeout_o); end
    calc_valid_i = 1'b1;
    calc_angle_i = 20'h11111;
    step();
    calc_valid_i = 1'b0;
    saw_valid = 1'b0;
    repeat (5) begin if (valid_o) saw_valid = 1'b1; step(); end
    tests_run++;
    if (saw_valid) begin tests_failed++; $display("FAIL to_stale: stale calc_valid_i produced valid_o=1, required 0"); end
    accept(3'b011, rdy, ok);
    req_valid_i = '0;
    tests_run++;
    if (!ok || rdy !== 3'b010) begin tests_failed++; $display("FAIL to_next_grant: ready=%b, required 010", rdy); end
    e = '{id: 2'd1, angle: 20'h00ABC, dds: model_dds(20'h00ABC)};
    sb_q.push_back(e);
    respond(5, 20'h00ABC);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin if (valid_o) got = 1'b1; else step(); end
    tests_run++;
    if (!got || sb_q.size() == 0) begin tests_failed++; $display("FAIL to_after_valid: valid_o not seen"); end
    else begin
      e = sb_q.pop_front();
      if ({CFO_id_o, CFO_angle_o, CFO_DDS_inc_o} !== {e.id, e.angle, e.dds}) begin
        tests_failed++;
        $display("FAIL to_after_result: id=%0d angle=%h dds=%h, required %0d %h %h", CFO_id_o, CFO_angle_o, CFO_DDS_inc_o, e.id, e.angle, e.dds);
      end
    end
  endtask

  task automatic test_final_cycle();
    logic [N_REQ-1:0] rdy;
    bit ok, got, saw_to;
    exp_t e;
    apply_reset();
    load_data();
    accept(3'b001, rdy, ok);
    req_valid_i = '0;
    saw_to = 1'b0;
    repeat (64) begin step(); if (timeout_o) saw_to = 1'b1; end
    e = '{id: 2'd0, angle: 20'hFFFFF, dds: model_dds(20'hFFFFF)};
    sb_q.push_back(e);
    calc_valid_i = 1'b1;
    calc_angle_i = 20'hFFFFF;
    step();
    calc_valid_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      if (timeout_o) saw_to = 1'b1;
      if (valid_o) got = 1'b1; else step();
    end
    tests_run++;
    if (!got || sb_q.size() == 0) begin tests_failed++; $display("FAIL final_valid: valid_o not seen for result on last cycle"); end
    else begin
      e = sb_q.pop_front();
      if ({CFO_id_o, CFO_angle_o, CFO_DDS_inc_o} !== {e.id, e.angle, e.dds}) begin
        tests_failed++;
        $display("FAIL final_result: id=%0d angle=%h dds=%h, required %0d %h %h", CFO_id_o, CFO_angle_o, CFO_DDS_inc_o, e.id, e.angle, e.dds);
      end
    end
    repeat (70) begin step(); if (timeout_o) saw_to = 1'b1; end
    tests_run++;
    if (saw_to) begin tests_failed++; $display("FAIL final_no_timeout: timeout_o=1, required 0"); end
  endtask

  task automatic test_avg();
    logic [N_REQ-1:0] rdy;
    logic [CFO_DW-1:0] angs [2];
    logic [DDS_DW-1:0] exp_dds [2];
    bit ok, got;
    angs[0] = 20'h08000;
    angs[1] = 20'h00000;
    exp_dds[0] = 20'h08000;
`ifdef CFO_AVG_EN
    exp_dds[1] = 20'h07000;
`else
    exp_dds[1] = 20'h00000;
`endif
    apply_reset();
    load_data();
    for (int n = 0; n < 2; n++) begin
      accept(3'b001, rdy, ok);
      req_valid_i = '0;
      void'(model_dds(angs[n]));
      sb_q.push_back('{id: 2'd0, angle: angs[n], dds: exp_dds[n]});
      respond(4, angs[n]);
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin if (valid_o) got = 1'b1; else step(); end
      tests_run++;
      if (!got || sb_q.size() == 0) begin tests_failed++; $display("FAIL avg_valid_%0d: valid_o not seen", n); end
      else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({CFO_angle_o, CFO_DDS_inc_o, DDS_valid_o} !== {e.angle, e.dds, 1'b1}) begin
          tests_failed++;
          $display("FAIL avg_result_%0d: angle=%h dds=%h dds_valid=%b, required %h %h 1", n, CFO_angle_o, CFO_DDS_inc_o, DDS_valid_o, e.angle, e.dds);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [N_REQ-1:0] rdy;
    bit ok, got;
    exp_t e;
    apply_reset();
    load_data();
    accept(3'b001, rdy, ok);
    req_valid_i = '0;
    e = '{id: 2'd0, angle: 20'h12345, dds: model_dds(20'h12345)};
    sb_q.push_back(e);
    respond(3, 20'h12345);
    repeat (2) step();
    accept(3'b010, rdy, ok);
    req_valid_i = '0;
    tests_run++;
    if (!ok || rdy !== 3'b010) begin tests_failed++; $display("FAIL rst_pre_grant: ready=%b, required 010", rdy); end
    repeat (10) step();
    #1 reset_ni = 1'b0;
    #1;
    tests_run++;
    if ({req_ready_o, calc_C0_o, calc_C1_o, calc_valid_o, CFO_angle_o, CFO_id_o, valid_o, timeout_o, CFO_DDS_inc_o, DDS_valid_o} !== '0) begin
      tests_failed++;
      $display("FAIL rst_async_outputs: C0=%h angle=%h id=%0d dds=%h, all required 0", calc_C0_o, CFO_angle_o, CFO_id_o, CFO_DDS_inc_o);
    end
    sb_q.delete();
    @(posedge clk_i);
    #1 reset_ni = 1'b1;
`ifdef CFO_AVG_EN
    model_init = 1'b0;
    model_avg = 0;
`endif
    step();
    accept(3'b101, rdy, ok);
    req_valid_i = '0;
    tests_run++;
    if (!ok || rdy !== 3'b001) begin tests_failed++; $display("FAIL rst_fresh_grant: ready=%b, required 001", rdy); end
    e = '{id: 2'd0, angle: 20'h0F0F0, dds: model_dds(20'h0F0F0)};
    sb_q.push_back(e);
    respond(2, 20'h0F0F0);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin if (valid_o) got = 1'b1; else step(); end
    tests_run++;
    if (!got || sb_q.size() == 0) begin tests_failed++; $display("FAIL rst_after_valid: valid_o not seen"); end
    else begin
      e = sb_q.pop_front();
      if ({CFO_id_o, CFO_angle_o, CFO_DDS_inc_o} !== {e.id, e.angle, e.dds}) begin
        tests_failed++;
        $display("FAIL rst_after_result: id=%0d angle=%h dds=%h, required %0d %h %h", CFO_id_o, CFO_angle_o, CFO_DDS_inc_o, e.id, e.angle, e.dds);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_final_cycle();
    test_avg();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
